// File: rtl/vip_dscale_ctrl_if.sv
// Control/status and video-timing bundle between the CPU/video side (master) and vip_dscale_ctrl (slave).
interface vip_dscale_ctrl_if;
  logic        cfg_en;
  logic        cfg_valid;
  logic [3:0]  cfg_dscale;
  logic        err_clr;
  logic        in_href;
  logic        in_vsync;
  logic [3:0]  dscale;
  logic        cfg_pending;
  logic        busy;
  logic        frame_done;
  logic [11:0] in_width;
  logic [11:0] in_height;
  logic [11:0] out_width;
  logic [11:0] out_height;
  logic [15:0] frame_cnt;
  logic        size_err;

  modport master (
    output cfg_en, cfg_valid, cfg_dscale, err_clr, in_href, in_vsync,
    input  dscale, cfg_pending, busy, frame_done, in_width, in_height,
           out_width, out_height, frame_cnt, size_err
  );

  modport slave (
    input  cfg_en, cfg_valid, cfg_dscale, err_clr, in_href, in_vsync,
    output dscale, cfg_pending, busy, frame_done, in_width, in_height,
           out_width, out_height, frame_cnt, size_err
  );
endinterface

// File: rtl/vip_dscale_ctrl.sv
// Frame-synchronous down-scale factor control with input/output geometry measurement.
// Optional geometry check against WIDTH/HEIGHT when DSCALE_CTRL_SIZE_CHECK_EN is defined.
module vip_dscale_ctrl #(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 960
) (
  input logic             pclk,
  input logic             rst_n,
  vip_dscale_ctrl_if.slave bus
);
  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] EXP_W   = 12'(WIDTH);
  localparam logic [11:0] EXP_H   = 12'(HEIGHT);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  state_t      state;
  logic        prev_href, prev_vsync;
  logic        sof, eof, ls, le, start;
  logic [3:0]  pend_q, dscale_q, ph, lph;
  logic        pending_q, busy_q, done_q;
  logic [11:0] pix_cnt, out_w, line_cnt, out_h, in_w_sh, out_w_sh;
  logic [11:0] in_w_nxt, out_w_nxt, line_nxt, out_h_nxt;
  logic [11:0] in_w_q, in_h_q, out_w_q, out_h_q;
  logic [15:0] frame_cnt_q;

  assign sof   = prev_vsync & ~bus.in_vsync;
  assign eof   = ~prev_vsync & bus.in_vsync;
  assign ls    = ~prev_href & bus.in_href;
  assign le    = prev_href & ~bus.in_href;
  assign start = (state == WAIT_SOF) && bus.cfg_en && sof;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  function automatic logic [3:0] ph_adv(input logic [3:0] p, input logic [3:0] lim);
    return (p == lim) ? 4'd0 : p + 4'd1;
  endfunction

  // Post-line-end view, so an eof landing on the same cycle as le still counts that line
  always_comb begin
    in_w_nxt  = in_w_sh;
    out_w_nxt = out_w_sh;
    line_nxt  = line_cnt;
    out_h_nxt = out_h;
    if (le) begin
      in_w_nxt  = pix_cnt;
      out_w_nxt = out_w;
      line_nxt  = sat_inc(line_cnt);
      if (lph == 4'd0) out_h_nxt = sat_inc(out_h);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_href  <= 1'b0;
      prev_vsync <= 1'b0;
    end else begin
      prev_href  <= bus.in_href;
      prev_vsync <= bus.in_vsync;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      out_w    <= '0;
      ph       <= '0;
      line_cnt <= '0;
      out_h    <= '0;
      lph      <= '0;
      in_w_sh  <= '0;
      out_w_sh <= '0;
    end else if (start) begin
      pix_cnt  <= '0;
      out_w    <= '0;
      ph       <= '0;
      line_cnt <= '0;
      out_h    <= '0;
      lph      <= '0;
      in_w_sh  <= '0;
      out_w_sh <= '0;
    end else if (state == ACTIVE) begin
      // the ls cycle is itself the first pixel, at phase 0
      if (ls) begin
        pix_cnt <= 12'd1;
        out_w   <= 12'd1;
        ph      <= ph_adv(4'd0, dscale_q);
      end else if (bus.in_href) begin
        pix_cnt <= sat_inc(pix_cnt);
        if (ph == 4'd0) out_w <= sat_inc(out_w);
        ph <= ph_adv(ph, dscale_q);
      end
      if (le) begin
        line_cnt <= line_nxt;
        out_h    <= out_h_nxt;
        lph      <= ph_adv(lph, dscale_q);
        in_w_sh  <= in_w_nxt;
        out_w_sh <= out_w_nxt;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_q      <= '0;
      pending_q   <= 1'b0;
      dscale_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_w_q      <= '0;
      in_h_q      <= '0;
      out_w_q     <= '0;
      out_h_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.cfg_valid) pend_q <= bus.cfg_dscale;
      // a request arriving on the applying sof stays pending for the next frame
      if (bus.cfg_valid)  pending_q <= 1'b1;
      else if (start)     pending_q <= 1'b0;
      case (state)
        IDLE: begin
          dscale_q <= '0;
          busy_q   <= 1'b0;
          if (bus.cfg_en) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (!bus.cfg_en) begin
            state    <= IDLE;
            dscale_q <= '0;
          end else if (sof) begin
            state    <= ACTIVE;
            dscale_q <= pend_q;
            busy_q   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (eof) begin
            in_w_q      <= in_w_nxt;
            in_h_q      <= line_nxt;
            out_w_q     <= out_w_nxt;
            out_h_q     <= out_h_nxt;
            done_q      <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            busy_q      <= 1'b0;
            if (bus.cfg_en) begin
              state <= WAIT_SOF;
            end else begin
              state    <= IDLE;
              dscale_q <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DSCALE_CTRL_SIZE_CHECK_EN
  logic size_err_q;
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      size_err_q <= 1'b0;
    else if (bus.err_clr)
      size_err_q <= 1'b0;
    else if ((state == ACTIVE) && eof && ((in_w_nxt != EXP_W) || (line_nxt != EXP_H)))
      size_err_q <= 1'b1;
  end
  assign bus.size_err = size_err_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{EXP_W, EXP_H, bus.err_clr};
  assign bus.size_err = 1'b0;
`endif

  assign bus.dscale      = dscale_q;
  assign bus.cfg_pending = pending_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.in_width    = in_w_q;
  assign bus.in_height   = in_h_q;
  assign bus.out_width   = out_w_q;
  assign bus.out_height  = out_h_q;
  assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vip_dscale_ctrl.sv
// Directed bench for vip_dscale_ctrl: geometry vector table plus hand sequences for multi-frame corners.
module tb_vip_dscale_ctrl;
  localparam int W_NOM = 40;
  localparam int H_NOM = 30;
  localparam int NV    = 9;

  typedef struct {
    logic [3:0] ds;
    int w, h, ew, eh, eow, eoh;
  } vec_t;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  vip_dscale_ctrl_if bus();

  vip_dscale_ctrl #(.WIDTH(W_NOM), .HEIGHT(H_NOM)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int dscale_bad = 0;
  logic [3:0] exp_act = 4'd0;

  always @(negedge pclk) begin
    if (bus.frame_done) done_seen++;
    if (bus.busy && (bus.dscale != exp_act)) dscale_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic start_frame();
    bus.in_vsync = 1'b0;
    tick(1);
  endtask

  task automatic lines(input int w, input int h);
    for (int l = 0; l < h; l++) begin
      bus.in_href = 1'b1;
      tick(w);
      bus.in_href = 1'b0;
      tick(3);
    end
  endtask

  task automatic end_frame();
    bus.in_vsync = 1'b1;
    tick(1);
  endtask

  task automatic request(input logic [3:0] ds);
    bus.cfg_valid  = 1'b1;
    bus.cfg_dscale = ds;
    tick(1);
    bus.cfg_valid  = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] ds, input int w, input int h,
                              input int ew, input int eh, input int eow, input int eoh);
    vec_t v;
    v.ds = ds; v.w = w; v.h = h; v.ew = ew; v.eh = eh; v.eow = eow; v.eoh = eoh;
    return v;
  endfunction

  initial begin
    vec_t vt[NV];
    int   exp_frames;
    int   d0, b0;
    logic exp_err;

    vt[0] = mk(4'd1,  40,   30,   40,   30,   20,   15);
    vt[1] = mk(4'd2,  40,   30,   40,   30,   14,   10);
    vt[2] = mk(4'd0,   7,    5,    7,    5,    7,    5);
    vt[3] = mk(4'd15, 17,   17,   17,   17,    2,    2);
    vt[4] = mk(4'd2,  1280,  4, 1280,    4,  427,    2);
    vt[5] = mk(4'd3,   5,    0,    0,    0,    0,    0);
    vt[6] = mk(4'd0,  4200,  1, 4095,    1, 4095,    1);
    vt[7] = mk(4'd4,   1,    9,    1,    9,    1,    2);
    vt[8] = mk(4'd1,  40,   30,   40,   30,   20,   15);

    bus.cfg_en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_dscale = 4'd0;
    bus.err_clr = 1'b0; bus.in_href = 1'b0; bus.in_vsync = 1'b1;
    exp_frames = 0;

    tick(3);
    chk("rst_dscale",      bus.dscale, 0);
    chk("rst_pending",     bus.cfg_pending, 0);
    chk("rst_busy",        bus.busy, 0);
    chk("rst_frame_done",  bus.frame_done, 0);
    chk("rst_in_width",    bus.in_width, 0);
    chk("rst_out_height",  bus.out_height, 0);
    chk("rst_frame_cnt",   bus.frame_cnt, 0);
    chk("rst_size_err",    bus.size_err, 0);
    rst_n = 1'b1;
    bus.cfg_en = 1'b1;
    tick(3);

    for (int i = 0; i < NV; i++) begin
      bus.err_clr = 1'b1;
      request(vt[i].ds);
      bus.err_clr = 1'b0;
      chk("pending_set", bus.cfg_pending, 1);
      exp_act = vt[i].ds;
      d0 = done_seen;
      b0 = dscale_bad;
      tick(2);
      start_frame();
      chk("applied_dscale", bus.dscale, 32'(vt[i].ds));
      chk("pending_clr", bus.cfg_pending, 0);
      lines(vt[i].w, vt[i].h);
      end_frame();
      exp_frames++;
      chk("in_width",   bus.in_width,   vt[i].ew);
      chk("in_height",  bus.in_height,  vt[i].eh);
      chk("out_width",  bus.out_width,  vt[i].eow);
      chk("out_height", bus.out_height, vt[i].eoh);
      chk("frame_cnt",  bus.frame_cnt,  exp_frames);
      chk("busy_end",   bus.busy, 0);
`ifdef DSCALE_CTRL_SIZE_CHECK_EN
      exp_err = (vt[i].ew != W_NOM) || (vt[i].eh != H_NOM);
`else
      exp_err = 1'b0;
`endif
      chk("size_err", bus.size_err, 32'(exp_err));
      tick(2);
      chk("done_pulses", done_seen - d0, 1);
      chk("dscale_steady", dscale_bad - b0, 0);
      tick(2);
    end

    // mid-frame request is held off until the following sof
    request(4'd1);
    exp_act = 4'd1;
    tick(2);
    start_frame();
    lines(10, 4);
    request(4'd3);
    chk("mid_dscale", bus.dscale, 1);
    chk("mid_pending", bus.cfg_pending, 1);
    lines(10, 4);
    end_frame();
    exp_frames++;
    chk("mid_eof_dscale", bus.dscale, 1);
    chk("mid_eof_pending", bus.cfg_pending, 1);
    tick(3);
    exp_act = 4'd3;
    start_frame();
    chk("next_dscale", bus.dscale, 3);
    chk("next_pending", bus.cfg_pending, 0);
    lines(10, 6);
    end_frame();
    exp_frames++;
    chk("next_out_width", bus.out_width, 3);
    chk("next_out_height", bus.out_height, 2);
    chk("next_frame_cnt", bus.frame_cnt, exp_frames);
    tick(3);

    // request on the sof edge itself applies one frame late
    request(4'd5);
    tick(2);
    exp_act = 4'd5;
    bus.in_vsync = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_dscale = 4'd6;
    tick(1);
    bus.cfg_valid = 1'b0;
    chk("coinc_dscale", bus.dscale, 5);
    chk("coinc_pending", bus.cfg_pending, 1);
    lines(6, 2);
    end_frame();
    exp_frames++;
    tick(3);
    exp_act = 4'd6;
    start_frame();
    chk("coinc_next_dscale", bus.dscale, 6);
    chk("coinc_next_pending", bus.cfg_pending, 0);
    lines(6, 2);
    end_frame();
    exp_frames++;
    chk("coinc_out_width", bus.out_width, 1);
    chk("coinc_frame_cnt", bus.frame_cnt, exp_frames);
    tick(3);

    // enable dropped mid-frame: frame completes, then controller idles
    start_frame();
    lines(6, 2);
    bus.cfg_en = 1'b0;
    tick(1);
    chk("dis_busy_held", bus.busy, 1);
    chk("dis_dscale_held", bus.dscale, 6);
    lines(6, 2);
    d0 = done_seen;
    end_frame();
    exp_frames++;
    chk("dis_busy_end", bus.busy, 0);
    chk("dis_dscale_zero", bus.dscale, 0);
    chk("dis_out_height", bus.out_height, 1);
    chk("dis_frame_cnt", bus.frame_cnt, exp_frames);
    tick(2);
    chk("dis_done_pulse", done_seen - d0, 1);
    d0 = done_seen;
    start_frame();
    chk("dis_no_busy", bus.busy, 0);
    lines(6, 2);
    end_frame();
    tick(2);
    chk("dis_no_done", done_seen - d0, 0);
    chk("dis_cnt_frozen", bus.frame_cnt, exp_frames);

    // geometry check and err_clr priority
    bus.cfg_en = 1'b1;
    tick(2);
    request(4'd0);
    exp_act = 4'd0;
    tick(2);
    start_frame();
    lines(W_NOM, H_NOM - 1);
    end_frame();
    exp_frames++;
    chk("err_in_height", bus.in_height, H_NOM - 1);
`ifdef DSCALE_CTRL_SIZE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    chk("err_set", bus.size_err, 32'(exp_err));
    tick(1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    chk("err_cleared", bus.size_err, 0);
    tick(2);
    start_frame();
    lines(W_NOM, H_NOM - 1);
    bus.in_vsync = 1'b1;
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    exp_frames++;
    chk("err_clr_priority", bus.size_err, 0);
    chk("err_frame_cnt", bus.frame_cnt, exp_frames);
    tick(3);

    // asynchronous reset mid-frame, then a clean frame
    start_frame();
    lines(20, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_dscale", bus.dscale, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_frame_cnt", bus.frame_cnt, 0);
    chk("arst_in_width", bus.in_width, 0);
    chk("arst_out_height", bus.out_height, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    request(4'd1);
    exp_act = 4'd1;
    d0 = done_seen;
    lines(20, 3);
    end_frame();
    tick(2);
    chk("arst_no_partial", done_seen - d0, 0);
    chk("arst_cnt_zero", bus.frame_cnt, 0);
    start_frame();
    lines(W_NOM, H_NOM);
    end_frame();
    chk("arst_in_width2", bus.in_width, W_NOM);
    chk("arst_in_height2", bus.in_height, H_NOM);
    chk("arst_out_width2", bus.out_width, W_NOM / 2);
    chk("arst_out_height2", bus.out_height, H_NOM / 2);
    chk("arst_frame_cnt2", bus.frame_cnt, 1);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vip_dscale_ctrl.md
# vip_dscale_ctrl

Frame-synchronous controller for the VIP down-scale stage. Accepts scale-factor requests from the CPU register side, applies them to the down-scaler only at frame start so no frame mixes two factors, and measures input and output frame geometry for software status. Sits beside the down-scaler on the same `pclk`, driving its `dscale` input.

## Interface
- `WIDTH`, 1280, nominal input line length in pixels; must be ≤ 4095.
- `HEIGHT`, 960, nominal input frame height in lines; must be ≤ 4095.

- `pclk`  in  1  pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_en`  in  1  controller enable, level. When low, pass-through (`dscale`=0).
- `cfg_valid`  in  1  one-cycle strobe; captures `cfg_dscale` as the pending request.
- `cfg_dscale`  in  4  requested factor minus 1 (0 = 1:1, 15 = 1:16).
- `err_clr`  in  1  one-cycle strobe; clears `size_err`.
- `in_href`  in  1  line valid, high during active pixels.
- `in_vsync`  in  1  vertical blanking, high between frames.
- `dscale`  out  4  applied factor to the down-scaler.
- `cfg_pending`  out  1  request captured but not yet applied.
- `busy`  out  1  high while a frame is being measured.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `in_width`, `in_height`  out  12 each  measured input geometry of the last frame.
- `out_width`, `out_height`  out  12 each  measured output geometry of the last frame.
- `frame_cnt`  out  16  completed-frame counter, wraps.
- `size_err`  out  1  sticky geometry mismatch flag.

## Operation
- Edge detection uses registered `prev_href` and `prev_vsync`.
  - `sof` = `prev_vsync & ~in_vsync`
  - `eof` = `~prev_vsync & in_vsync`
  - `ls` = `~prev_href & in_href`
  - `le` = `prev_href & ~in_href`
- `cfg_valid` loads `pend_q` from `cfg_dscale` and sets `cfg_pending`. A later `cfg_valid` before application overwrites it; last write wins.
- FSM states: IDLE, WAIT_SOF, ACTIVE.
  - IDLE: `dscale`=0. Leaves to WAIT_SOF when `cfg_en`=1.
  - WAIT_SOF: goes to IDLE if `cfg_en`=0. On `sof`, goes to ACTIVE and sets `dscale` to `pend_q`. `cfg_pending` clears on the same edge.
  - ACTIVE: `busy`=1. On `eof`:
    - latch the four geometry outputs;
    - pulse `frame_done` and increment `frame_cnt`;
    - go to WAIT_SOF if `cfg_en`=1, else go to IDLE and clear `dscale` to 0.
- Measurement while ACTIVE:
  - `pix_cnt` counts `in_href` cycles and clears on `ls`. On `le` it is copied to the `in_width` shadow.
  - `out_w` counts pixels with phase==0. Phase cycles 0..`dscale` and resets on `ls`. On `le` it is copied to the `out_width` shadow. The result is `ceil(pixels/(dscale+1))`; no divider is used.
  - `line_cnt` counts `le` events. `out_h` counts `le` events with line phase==0. Line phase cycles 0..`dscale` on `le` and resets on `sof`.
  - All counters saturate at 4095.
- Width outputs report the last completed line of the frame. A frame with no lines reports 0 for all four geometry outputs.
- A `cfg_valid` coincident with `sof` still loads `pend_q`, but the value applied on that `sof` is the old `pend_q`. The new value applies one frame later.
- `cfg_en` falling mid-frame has no effect until `eof`.
- Reset mid-frame: all state returns to reset values. The controller resumes at the next `sof` after `cfg_en`. No partial frame is reported.

## Timing
- Reset values:
  - `dscale`=0, `cfg_pending`=0, `busy`=0, `frame_done`=0;
  - all geometry outputs 0, `frame_cnt`=0, `size_err`=0;
  - FSM in IDLE, `pend_q`=0.
- `dscale` changes on the `pclk` edge where `sof` is true, i.e. one cycle after `in_vsync` falls. It is constant until the next `sof` or `eof`.
- `frame_done` and the geometry updates occur on the edge where `eof` is true, one cycle after `in_vsync` rises. Geometry is stable until the next `eof`.
- `cfg_pending` sets one cycle after `cfg_valid`.
- `err_clr` takes priority over a `size_err` set in the same cycle.

## Configuration
- `DSCALE_CTRL_SIZE_CHECK_EN` defined: on each `eof`, `size_err` sets if `in_width`≠`WIDTH` or `in_height`≠`HEIGHT`, using the values being latched. It stays set until `err_clr`.
- Undefined: compare logic is absent and `size_err` is tied 0.

## Test plan
- `cfg_dscale`=1, `cfg_en`=1, one 1280×960 frame -> after `eof`:
  - `in_width`=1280, `in_height`=960, `out_width`=640, `out_height`=480;
  - `frame_done` pulses once, `frame_cnt`=1.
- `cfg_dscale`=2, 1280×960 -> `out_width`=427, `out_height`=320, `dscale`=2 throughout the frame.
- `cfg_valid`(3) mid-frame while `dscale`=1 -> `dscale` stays 1 and `cfg_pending`=1 until next `sof`, then `dscale`=3 and `cfg_pending`=0.
- `cfg_en` dropped mid-frame -> `busy` held until `eof`, then IDLE with `dscale`=0. The next frame produces no `frame_done`.
- With macro defined, 1280×959 frame -> `size_err`=1 after `eof`; `err_clr` returns it to 0. Without macro -> `size_err` stays 0.
- `rst_n` pulsed mid-frame -> all outputs 0 immediately. The next full frame after re-enable reports correct geometry with `frame_cnt`=1.
